// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU path.
//   OP_ADD/OP_SUB/OP_AND/OP_OR : 2-bit opcodes carried in bits [1:0] of the opcode byte
//   state_t                    : frame sequencer state encoding
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_A  = 3'd1,
        GET_B  = 3'd2,
        EXEC   = 3'd3,
        RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/alu_core_8b.sv
// Purely combinational ALU core.
//   a, b  : operands (WIDTH bits, unsigned)
//   op    : OP_ADD / OP_SUB / OP_AND / OP_OR
//   res   : result, WIDTH bits
//   carry : ADD carry-out, SUB borrow (a < b), 0 for logic ops
module alu_core_8b
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        // The extra top bit of an unsigned subtraction is the borrow, i.e. a < b.
        diff  = {1'b0, a} - {1'b0, b};
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
            end
            OP_AND: res = a & b;
            default: res = a | b;
        endcase
    end

endmodule

// File: rtl/alu_frame_sequencer.sv
// Host-side initiator for the ALU: collects a 3-byte frame (opcode, A, B) over a
// valid/ready byte stream, runs one operation and returns the result over valid/ready.
//   clk, rst              : clock, synchronous active-high reset
//   in_data/in_valid/in_ready    : frame byte stream
//   out_data/out_carry/out_valid/out_ready : result handshake (held until accepted)
//   busy                  : high whenever not idle
//   timeout_err           : one-cycle pulse when a partial frame is abandoned
module alu_frame_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             timeout_err
);

    // The counter only has to represent 0 .. TIMEOUT-1: the abort happens on the edge
    // where it would reach TIMEOUT.
    localparam int                 CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                 TO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state;
    state_t             state_n;

    logic               in_fire;
    logic               out_fire;
    logic               in_get;
    logic               to_hit;
    logic [CNT_W-1:0]   to_cnt;

    logic [1:0]         op_p0;
    logic [WIDTH-1:0]   a_p0;
    logic [WIDTH-1:0]   b_p0;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;

    logic [WIDTH-1:0]   res_p1;
    logic               carry_p1;
    logic               vld_p1;

    // Opcode bits above [1:0] carry no meaning.
    logic               unused_op_bits;
    assign unused_op_bits = ^in_data[WIDTH-1:2];

    assign in_get   = (state == GET_A) || (state == GET_B);
    assign in_ready = (state == IDLE) || in_get;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state != IDLE);
    // A byte accepted on the same edge beats the timeout (in_valid=0 is required).
    assign to_hit   = TO_EN && in_get && !in_valid && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (in_fire) state_n = GET_A;
            end
            GET_A: begin
                if (in_fire)     state_n = GET_B;
                else if (to_hit) state_n = IDLE;
            end
            GET_B: begin
                if (in_fire)     state_n = EXEC;
                else if (to_hit) state_n = IDLE;
            end
            EXEC:   state_n = RESULT;
            // Leave only once the registered result has actually been handed over.
            RESULT: begin
                if (out_fire) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                              to_cnt <= '0;
        else if (in_get && !in_valid && !to_hit) to_cnt <= to_cnt + 1'b1;
        else                                  to_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) timeout_err <= 1'b0;
        else     timeout_err <= to_hit;
    end

    // ---- stage p0: operand capture from the byte stream ----
    always_ff @(posedge clk) begin
        if (in_fire) begin
            case (state)
                IDLE:    op_p0 <= in_data[1:0];
                GET_A:   a_p0  <= in_data;
                GET_B:   b_p0  <= in_data;
                default: ;
            endcase
        end
    end

    alu_core_8b #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a_p0),
        .b     (b_p0),
        .op    (op_p0),
        .res   (alu_res),
        .carry (alu_carry)
    );

    // ---- stage p1: ALU result registered during EXEC ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= (state == EXEC);
    end

    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            res_p1   <= alu_res;
            carry_p1 <= alu_carry;
        end
    end

    // ---- stage p2: output register, held until the consumer accepts ----
    always_ff @(posedge clk) begin
        if (rst)           out_valid <= 1'b0;
        else if (vld_p1)   out_valid <= 1'b1;
        else if (out_fire) out_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_carry <= 1'b0;
        end else if (vld_p1) begin
            out_data  <= res_p1;
            out_carry <= carry_p1;
        end
    end

endmodule
